mm_job_sched: RTL and testbench

Job scheduler and sequencer for the scalable radix-4 Montgomery multiplier core. Arbitrates round-robin between two requesters that share one core. For the granted requester it drives the core enable and paces operand word delivery across all lambda passes. It then captures the serial result words from the core's S output into a result-write stream and signals completion to the owner.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_rr_arb2.sv | 25 ++
 rtl/mm_job_sched.sv | 167 ++++++++++++++++
 tb/tb_mm_job_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the Montgomery multiplier job scheduler:
// FSM encoding and sizing helpers used to derive counter and index widths.
package mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int nwords(input int k, input int w);
        return k / w + 1;
    endfunction

    function automatic int word_cyc(input int w);
        return w / 2 - 1;
    endfunction

endpackage

// File: rtl/mm_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last owner and
// is only advanced when that owner's job completes.
module mm_rr_arb2 (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_id,
    output logic [1:0] win
);

    logic rr;

    // rr starts at 1 so requester 0 wins the first tie
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)   rr <= 1'b1;
        else if (upd) rr <= upd_id;
    end

    always_comb begin
        win = req;
        if (req == 2'b11) win = rr ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/mm_job_sched.sv
// Job scheduler for the radix-4 Montgomery core: grants one requester, paces
// operand slots across all passes and captures the serial S result words.
// state | meaning
// IDLE  | core held in reset, arbitrate pending requests
// RUN   | core enabled, operand feed and result capture running
// DONE  | one-cycle completion pulse, core reset, arbiter pointer update
module mm_job_sched
    import mm_pkg::*;
#(
    parameter int K       = 1024,
    parameter int W       = 16,
    parameter int LAMDA   = 1,
    parameter int STALL   = 0,
    parameter int RES_LAT = 200,
    localparam int NWORDS   = nwords(K, W),
    localparam int WORD_CYC = word_cyc(W),
    localparam int SLOTS    = NWORDS + STALL,
    localparam int IW       = clog2(NWORDS),
    localparam int LW       = clog2(LAMDA) + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic          busy,
    output logic          core_en,
    output logic          feed_stb,
    output logic          feed_pad,
    output logic [IW-1:0] word_idx,
    output logic [LW-1:0] lamda_idx,
    input  logic [W-1:0]  core_s,
    output logic          res_we,
    output logic [IW-1:0] res_idx,
    output logic [W-1:0]  res_data
);

    localparam int TOTAL = LAMDA * SLOTS;
    localparam int SW    = clog2(SLOTS + 1);
    localparam int SLW   = clog2(TOTAL + 1);
    localparam int FTW   = clog2(WORD_CYC + 1);
    localparam int RTW   = clog2(((RES_LAT > WORD_CYC) ? RES_LAT : WORD_CYC) + 1);

    localparam logic [IW-1:0]  IDX_LAST  = IW'(NWORDS - 1);
    localparam logic [SW-1:0]  S_LAST    = SW'(SLOTS - 1);
    localparam logic [SW-1:0]  S_PAD     = SW'(NWORDS);
    localparam logic [SLW-1:0] SLOT_END  = SLW'(TOTAL);
    localparam logic [SLW-1:0] SLOT_LAST = SLW'(TOTAL - 1);
    localparam logic [FTW-1:0] FT_LOAD   = FTW'(WORD_CYC - 1);
    localparam logic [RTW-1:0] RT_LAT    = RTW'(RES_LAT);
    localparam logic [RTW-1:0] RT_WORD   = RTW'(WORD_CYC - 1);

    state_t         state;
    logic           owner;
    logic [1:0]     win;
    logic [SLW-1:0] slot;
    logic [SW-1:0]  s_cnt;
    logic [SW-1:0]  s_inc;
    logic [FTW-1:0] feed_tc;
    logic [RTW-1:0] res_tc;
    logic [IW-1:0]  wr_cnt;

    assign s_inc = s_cnt + 1'b1;

    mm_rr_arb2 u_arb (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .req    (req),
        .upd    (state == ST_DONE),
        .upd_id (owner),
        .win    (win)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            gnt       <= '0;
            done      <= '0;
            busy      <= 1'b0;
            core_en   <= 1'b0;
            feed_stb  <= 1'b0;
            feed_pad  <= 1'b0;
            word_idx  <= '0;
            lamda_idx <= '0;
            res_we    <= 1'b0;
            res_idx   <= '0;
            res_data  <= '0;
            slot      <= '0;
            s_cnt     <= '0;
            feed_tc   <= '0;
            res_tc    <= '0;
            wr_cnt    <= '0;
        end else begin
            done   <= '0;
            res_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state     <= ST_RUN;
                        owner     <= win[1];
                        gnt       <= win;
                        busy      <= 1'b1;
                        core_en   <= 1'b1;
                        feed_stb  <= 1'b1;
                        feed_pad  <= 1'b0;
                        word_idx  <= '0;
                        lamda_idx <= '0;
                        res_idx   <= '0;
                        slot      <= '0;
                        s_cnt     <= '0;
                        feed_tc   <= FT_LOAD;
                        res_tc    <= RT_LAT;
                        wr_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    // feed_tc counts down to the start of the next operand slot
                    if (feed_tc == '0) begin
                        feed_tc <= FT_LOAD;
                        if (slot != SLOT_END) slot <= slot + 1'b1;
                        if (slot < SLOT_LAST) begin
                            feed_stb <= 1'b1;
                            if (s_cnt == S_LAST) begin
                                s_cnt     <= '0;
                                word_idx  <= '0;
                                feed_pad  <= 1'b0;
                                lamda_idx <= lamda_idx + 1'b1;
                            end else begin
                                s_cnt    <= s_inc;
                                word_idx <= (s_inc == S_PAD) ? IDX_LAST : IW'(s_inc);
                                feed_pad <= (s_inc == S_PAD);
                            end
                        end else begin
                            feed_stb <= 1'b0;
                        end
                    end else begin
                        feed_tc  <= feed_tc - 1'b1;
                        feed_stb <= 1'b0;
                    end

                    if (res_tc == '0) begin
                        res_tc   <= RT_WORD;
                        res_we   <= 1'b1;
                        res_data <= core_s;
                        res_idx  <= wr_cnt;
                        wr_cnt   <= wr_cnt + 1'b1;
                    end else begin
                        res_tc <= res_tc - 1'b1;
                    end

                    if (res_we && res_idx == IDX_LAST) begin
                        state    <= ST_DONE;
                        done     <= gnt;
                        gnt      <= '0;
                        busy     <= 1'b0;
                        core_en  <= 1'b0;
                        feed_stb <= 1'b0;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_sched.sv
// Directed bench for mm_job_sched: K=32, W=8, RES_LAT=20 (5 words, 3 cycles
// per word) in a single-pass instance and a two-pass instance with a stall slot.
module tb_mm_job_sched;

    logic       CLK;
    logic       RST_N;
    logic [1:0] req_a, req_b;
    logic [7:0] core_s;

    logic [1:0] gnt_a, done_a, gnt_b, done_b;
    logic       busy_a, core_en_a, feed_stb_a, feed_pad_a, res_we_a;
    logic       busy_b, core_en_b, feed_stb_b, feed_pad_b, res_we_b;
    logic [2:0] word_idx_a, res_idx_a, word_idx_b, res_idx_b;
    logic [0:0] lamda_idx_a;
    logic [1:0] lamda_idx_b;
    logic [7:0] res_data_a, res_data_b;

    int total = 0;
    int bad   = 0;

    mm_job_sched #(.K(32), .W(8), .LAMDA(1), .STALL(0), .RES_LAT(20)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .req(req_a), .gnt(gnt_a), .done(done_a),
        .busy(busy_a), .core_en(core_en_a), .feed_stb(feed_stb_a),
        .feed_pad(feed_pad_a), .word_idx(word_idx_a), .lamda_idx(lamda_idx_a),
        .core_s(core_s), .res_we(res_we_a), .res_idx(res_idx_a), .res_data(res_data_a)
    );

    mm_job_sched #(.K(32), .W(8), .LAMDA(2), .STALL(1), .RES_LAT(20)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .req(req_b), .gnt(gnt_b), .done(done_b),
        .busy(busy_b), .core_en(core_en_b), .feed_stb(feed_stb_b),
        .feed_pad(feed_pad_b), .word_idx(word_idx_b), .lamda_idx(lamda_idx_b),
        .core_s(core_s), .res_we(res_we_b), .res_idx(res_idx_b), .res_data(res_data_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // core_s carries a distinct word only on the cycles the scheduler must sample
    task automatic drive_core_s(input int c);
        core_s = (c >= 20 && (c - 20) % 3 == 0) ? 8'(8'hA0 + (c - 20) / 3) : 8'h5A;
    endtask

    task automatic chk_reset_a(input int tag_cyc);
        chk("rst_gnt",      tag_cyc, gnt_a,       0);
        chk("rst_done",     tag_cyc, done_a,      0);
        chk("rst_busy",     tag_cyc, busy_a,      0);
        chk("rst_core_en",  tag_cyc, core_en_a,   0);
        chk("rst_feed_stb", tag_cyc, feed_stb_a,  0);
        chk("rst_feed_pad", tag_cyc, feed_pad_a,  0);
        chk("rst_word_idx", tag_cyc, word_idx_a,  0);
        chk("rst_lamda",    tag_cyc, lamda_idx_a, 0);
        chk("rst_res_we",   tag_cyc, res_we_a,    0);
        chk("rst_res_idx",  tag_cyc, res_idx_a,   0);
        chk("rst_res_data", tag_cyc, res_data_a,  0);
    endtask

    // Entered with grant cycle 0 visible; leaves with the done cycle (34) visible.
    task automatic run_a(input logic [1:0] who, input int drop_at);
        for (int c = 0; c <= 34; c++) begin
            automatic bit exp_feed = (c % 3 == 0) && (c <= 12);
            automatic bit exp_we   = (c >= 21) && (c <= 33) && ((c - 21) % 3 == 0);
            chk("a_gnt",      c, gnt_a,      (c <= 33) ? 32'(who) : 32'd0);
            chk("a_busy",     c, busy_a,     (c <= 33) ? 32'd1 : 32'd0);
            chk("a_core_en",  c, core_en_a,  (c <= 33) ? 32'd1 : 32'd0);
            chk("a_done",     c, done_a,     (c == 34) ? 32'(who) : 32'd0);
            chk("a_feed_stb", c, feed_stb_a, 32'(exp_feed));
            chk("a_res_we",   c, res_we_a,   32'(exp_we));
            if (exp_feed) begin
                chk("a_word_idx", c, word_idx_a,  c / 3);
                chk("a_lamda",    c, lamda_idx_a, 0);
                chk("a_feed_pad", c, feed_pad_a,  0);
            end
            if (exp_we) begin
                chk("a_res_idx",  c, res_idx_a,  (c - 21) / 3);
                chk("a_res_data", c, res_data_a, 32'hA0 + (c - 21) / 3);
            end
            if (c == drop_at) req_a = 2'b00;
            drive_core_s(c);
            if (c < 34) tick();
        end
    endtask

    task automatic run_b();
        automatic int nstb = 0;
        for (int c = 0; c <= 34; c++) begin
            automatic bit exp_feed = (c % 3 == 0) && (c <= 33);
            automatic bit exp_we   = (c >= 21) && (c <= 33) && ((c - 21) % 3 == 0);
            automatic int k = c / 3;
            chk("b_gnt",      c, gnt_b,      (c <= 33) ? 32'd1 : 32'd0);
            chk("b_core_en",  c, core_en_b,  (c <= 33) ? 32'd1 : 32'd0);
            chk("b_done",     c, done_b,     (c == 34) ? 32'd1 : 32'd0);
            chk("b_feed_stb", c, feed_stb_b, 32'(exp_feed));
            chk("b_res_we",   c, res_we_b,   32'(exp_we));
            if (feed_stb_b) nstb++;
            if (exp_feed) begin
                chk("b_word_idx", c, word_idx_b,  (k % 6 == 5) ? 4 : k % 6);
                chk("b_feed_pad", c, feed_pad_b,  (k % 6 == 5) ? 1 : 0);
                chk("b_lamda",    c, lamda_idx_b, k / 6);
            end
            if (exp_we) begin
                chk("b_res_idx",  c, res_idx_b,  (c - 21) / 3);
                chk("b_res_data", c, res_data_b, 32'hA0 + (c - 21) / 3);
            end
            drive_core_s(c);
            if (c < 34) tick();
        end
        chk("b_strobe_count", 34, nstb, 12);
    endtask

    initial begin
        RST_N  = 1'b0;
        req_a  = 2'b00;
        req_b  = 2'b00;
        core_s = 8'h00;
        #12;
        chk_reset_a(-1);
        chk("rst_b_gnt",     -1, gnt_b,     0);
        chk("rst_b_core_en", -1, core_en_b, 0);
        RST_N = 1'b1;

        // single job, requester 0
        req_a = 2'b01;
        tick();
        run_a(2'b01, -1);
        req_a = 2'b00;
        tick();
        chk("idle_gnt",     35, gnt_a,     0);
        chk("idle_core_en", 35, core_en_a, 0);
        chk("idle_done",    35, done_a,    0);
        chk("idle_busy",    35, busy_a,    0);

        // two passes with a stall slot
        req_b = 2'b01;
        tick();
        run_b();
        req_b = 2'b00;
        tick();
        chk("b_idle_gnt", 35, gnt_b, 0);

        // requester 1 drops req mid-job; job still completes
        req_a = 2'b10;
        tick();
        run_a(2'b10, 5);

        // re-request on the done cycle: one idle cycle, then granted
        req_a = 2'b01;
        tick();
        chk("b2b_idle_core_en", 35, core_en_a, 0);
        chk("b2b_idle_gnt",     35, gnt_a,     0);
        tick();
        run_a(2'b01, -1);

        // contention from reset: 0, then 1, then 0
        RST_N = 1'b0;
        #1;
        chk_reset_a(-2);
        req_a = 2'b11;
        #1;
        RST_N = 1'b1;
        tick();
        run_a(2'b01, -1);
        tick();
        chk("rr_idle_gnt",  35, gnt_a,  0);
        chk("rr_idle_busy", 35, busy_a, 0);
        tick();
        run_a(2'b10, -1);
        tick();
        chk("rr_idle2_gnt", 35, gnt_a, 0);
        tick();
        chk("rr_third_gnt", 0, gnt_a, 2'b01);

        // asynchronous reset mid-job
        for (int c = 1; c <= 10; c++) tick();
        chk("mid_core_en_pre", 10, core_en_a, 1);
        RST_N = 1'b0;
        #1;
        chk_reset_a(10);
        req_a = 2'b10;
        tick();
        chk("mid_held_done", 11, done_a, 0);
        chk("mid_held_gnt",  11, gnt_a,  0);
        #2;
        RST_N = 1'b1;
        tick();
        chk("post_rst_gnt",      0, gnt_a,      2'b10);
        chk("post_rst_core_en",  0, core_en_a,  1);
        chk("post_rst_feed_stb", 0, feed_stb_a, 1);
        chk("post_rst_word_idx", 0, word_idx_a, 0);
        chk("post_rst_done",     0, done_a,     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
